// File: rtl/ucie_ctl_tx_mc_pkg.sv
// Shared link-state codes and controller state encoding for the UCIe
// multi-channel transmit path.
package ucie_ctl_pkg;

    localparam logic [3:0] STS_RESET   = 4'b0000;
    localparam logic [3:0] STS_ACTIVE  = 4'b0001;
    localparam logic [3:0] STS_RETRAIN = 4'b1011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } ctl_state_e;

endpackage

// File: rtl/ucie_ctl_tx_mc_if.sv
// FDI producer side and RDI transmit side of one die-to-die link, named from
// the controller's point of view (i_ = into the controller, o_ = out of it).
interface ucie_ctl_tx_mc_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 64,
    parameter int CH_W   = 1
);

    logic [3:0]               i_fdi_pl_state_sts;
    logic [NUM_CH-1:0]        i_fdi_lp_valid;
    logic [NUM_CH-1:0]        i_fdi_lp_irdy;
    logic [NUM_CH*DATA_W-1:0] i_fdi_lp_data;
    logic [NUM_CH-1:0]        o_fdi_pl_trdy;
    logic                     i_rdi_pl_trdy;
    logic                     o_rdi_lp_valid;
    logic                     o_rdi_lp_irdy;
    logic [DATA_W-1:0]        o_rdi_lp_data;
    logic [CH_W-1:0]          o_rdi_lp_ch;
    logic [NUM_CH-1:0]        o_tx_overf_err;
    logic                     o_tx_drained;

    modport slave (
        input  i_fdi_pl_state_sts, i_fdi_lp_valid, i_fdi_lp_irdy, i_fdi_lp_data,
        input  i_rdi_pl_trdy,
        output o_fdi_pl_trdy, o_rdi_lp_valid, o_rdi_lp_irdy, o_rdi_lp_data,
        output o_rdi_lp_ch, o_tx_overf_err, o_tx_drained
    );

    modport master (
        output i_fdi_pl_state_sts, i_fdi_lp_valid, i_fdi_lp_irdy, i_fdi_lp_data,
        output i_rdi_pl_trdy,
        input  o_fdi_pl_trdy, o_rdi_lp_valid, o_rdi_lp_irdy, o_rdi_lp_data,
        input  o_rdi_lp_ch, o_tx_overf_err, o_tx_drained
    );

endinterface

// File: rtl/ucie_ctl_tx_mc_sync_fifo.sv
// Per-channel first-word-fall-through FIFO with a synchronous flush; pointers
// carry one extra wrap bit so full and empty can be told apart.
module ucie_ctl_sync_fifo #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              w_do_wr;
    logic              w_do_rd;

    assign w_do_wr   = i_wr_en & ~o_full;
    assign w_do_rd   = i_rd_en & ~o_empty;
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                       (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign o_rd_data = r_mem[r_rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_wr && !i_flush) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/ucie_ctl_tx_mc.sv
// UCIe transmit path: NUM_CH FDI channels buffered per channel, merged
// round-robin onto one registered RDI port, gated by the FDI link state.
module ucie_ctl_tx_mc
    import ucie_ctl_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = $clog2(FIFO_DEPTH),
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    ucie_ctl_tx_mc_if.slave io_bus
);

    ctl_state_e        r_state;
    ctl_state_e        w_next_state;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_trdy;
    logic [NUM_CH-1:0] w_wr_en;
    logic [NUM_CH-1:0] w_rd_en;
    logic [DATA_W-1:0] w_rd_data [NUM_CH];
    logic              w_flush;
    logic              w_found;
    logic              w_load;
    logic [CH_W-1:0]   w_grant;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CH_W-1:0]   r_ch;
    logic [CH_W-1:0]   r_last_grant;
    logic [NUM_CH-1:0] r_overf;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (io_bus.i_fdi_pl_state_sts == STS_ACTIVE) w_next_state = ACTIVE;
            ACTIVE:  if (io_bus.i_fdi_pl_state_sts == STS_RETRAIN) w_next_state = DRAIN;
                     else if (io_bus.i_fdi_pl_state_sts != STS_ACTIVE) w_next_state = IDLE;
            DRAIN:   if (io_bus.i_fdi_pl_state_sts == STS_ACTIVE) w_next_state = ACTIVE;
                     else if (io_bus.i_fdi_pl_state_sts != STS_RETRAIN) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Flushing on the next state lets a drop out of ACTIVE/DRAIN empty the
    // FIFOs and kill the RDI flit on the very edge that samples the new code.
    assign w_flush = (w_next_state == IDLE);
    assign w_push  = io_bus.i_fdi_lp_valid & io_bus.i_fdi_lp_irdy;
    assign w_trdy  = {NUM_CH{r_state == ACTIVE}} & ~w_full;
    assign w_wr_en = w_push & w_trdy;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ucie_ctl_sync_fifo #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_fifo (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_flush   (w_flush),
            .i_wr_en   (w_wr_en[c]),
            .i_wr_data (io_bus.i_fdi_lp_data[c*DATA_W +: DATA_W]),
            .i_rd_en   (w_rd_en[c]),
            .o_full    (w_full[c]),
            .o_empty   (w_empty[c]),
            .o_rd_data (w_rd_data[c])
        );
    end

    always_comb begin : p_arb
        logic [CH_W-1:0] w_idx;
        w_idx   = '0;
        w_grant = '0;
        w_found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = CH_W'((int'(r_last_grant) + i) % NUM_CH);
            if (!w_found && !w_empty[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    assign w_load = ((r_state == ACTIVE) || (r_state == DRAIN)) &&
                    (!r_valid || io_bus.i_rdi_pl_trdy) && w_found;

    always_comb begin
        w_rd_en = '0;
        if (w_load) w_rd_en[w_grant] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_ch         <= '0;
            r_last_grant <= CH_W'(NUM_CH - 1);
        end else if (w_flush) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
        end else if (w_load) begin
            r_valid      <= 1'b1;
            r_data       <= w_rd_data[w_grant];
            r_ch         <= w_grant;
            r_last_grant <= w_grant;
        end else if (r_valid && io_bus.i_rdi_pl_trdy) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
        end
    end

    // Overflow flags are sticky until reset; leaving ACTIVE does not clear them.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                  r_overf <= '0;
        else if (r_state == ACTIVE) r_overf <= r_overf | (w_push & w_full);
    end

    assign io_bus.o_fdi_pl_trdy  = w_trdy;
    assign io_bus.o_rdi_lp_valid = r_valid;
    assign io_bus.o_rdi_lp_irdy  = r_valid;
    assign io_bus.o_rdi_lp_data  = r_data;
    assign io_bus.o_rdi_lp_ch    = r_ch;
    assign io_bus.o_tx_overf_err = r_overf;
    assign io_bus.o_tx_drained   = (r_state == DRAIN) && (&w_empty) && !r_valid;

endmodule

// File: tb/tb_ucie_ctl_tx_mc.sv
// Directed self-checking bench for ucie_ctl_tx_mc with two channels of
// 64-bit flits and eight-entry FIFOs; inputs change and outputs are read on negedge.
module tb_ucie_ctl_tx_mc;
    import ucie_ctl_pkg::*;

    localparam int NUM_CH     = 2;
    localparam int DATA_W     = 64;
    localparam int FIFO_DEPTH = 8;
    localparam int CH_W       = 1;

    logic clk = 1'b0;
    logic rst;
    int   nCompared   = 0;
    int   nMismatched = 0;

    ucie_ctl_tx_mc_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) bus ();

    ucie_ctl_tx_mc #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clearInputs();
        bus.i_fdi_lp_valid = '0;
        bus.i_fdi_lp_irdy  = '0;
        bus.i_fdi_lp_data  = '0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        bus.i_fdi_pl_state_sts = STS_RESET;
        bus.i_rdi_pl_trdy = 1'b0;
        clearInputs();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic goActive();
        bus.i_fdi_pl_state_sts = STS_ACTIVE;
        step();
    endtask

    task automatic driveFlit(input int ch, input logic [DATA_W-1:0] d);
        bus.i_fdi_lp_valid[ch] = 1'b1;
        bus.i_fdi_lp_irdy[ch]  = 1'b1;
        bus.i_fdi_lp_data[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_fdi_pl_state_sts = STS_ACTIVE;
        bus.i_rdi_pl_trdy = 1'b1;
        clearInputs();
        step();
        step();
        nCompared++;
        if (bus.o_rdi_lp_valid !== 1'b0 || bus.o_rdi_lp_irdy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_valid: got valid=%b irdy=%b expected 0/0", bus.o_rdi_lp_valid, bus.o_rdi_lp_irdy);
        end
        nCompared++;
        if (bus.o_rdi_lp_data !== 64'h0 || bus.o_rdi_lp_ch !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_data: got data=%h ch=%0d expected 0/0", bus.o_rdi_lp_data, bus.o_rdi_lp_ch);
        end
        nCompared++;
        if (bus.o_fdi_pl_trdy !== 2'b00 || bus.o_tx_overf_err !== 2'b00 || bus.o_tx_drained !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_flags: got trdy=%b overf=%b drained=%b expected 00/00/0",
                     bus.o_fdi_pl_trdy, bus.o_tx_overf_err, bus.o_tx_drained);
        end
        bus.i_fdi_pl_state_sts = STS_RESET;
        rst = 1'b0;
        step();
        nCompared++;
        if (bus.o_fdi_pl_trdy !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL idle_trdy: got %b expected 00", bus.o_fdi_pl_trdy);
        end
    endtask

    task automatic test_single_flow();
        resetDut();
        goActive();
        nCompared++;
        if (bus.o_fdi_pl_trdy !== 2'b11) begin
            nMismatched++;
            $display("[TB] FAIL single_trdy: got %b expected 11", bus.o_fdi_pl_trdy);
        end
        driveFlit(0, 64'hA5);
        bus.i_rdi_pl_trdy = 1'b1;
        step();
        clearInputs();
        nCompared++;
        if (bus.o_rdi_lp_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL single_early: got valid=%b expected 0", bus.o_rdi_lp_valid);
        end
        step();
        nCompared++;
        if (bus.o_rdi_lp_valid !== 1'b1 || bus.o_rdi_lp_irdy !== 1'b1 ||
            bus.o_rdi_lp_data !== 64'hA5 || bus.o_rdi_lp_ch !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL single_flit: got v=%b irdy=%b data=%h ch=%0d expected 1/1/a5/0",
                     bus.o_rdi_lp_valid, bus.o_rdi_lp_irdy, bus.o_rdi_lp_data, bus.o_rdi_lp_ch);
        end
        step();
        nCompared++;
        if (bus.o_rdi_lp_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL single_drop: got valid=%b expected 0", bus.o_rdi_lp_valid);
        end
    endtask

    task automatic test_round_robin();
        int idx;
        logic [DATA_W-1:0] expData;
        logic [CH_W-1:0]   expCh;
        resetDut();
        goActive();
        bus.i_rdi_pl_trdy = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            clearInputs();
            if (cyc < 3) begin
                driveFlit(0, 64'h100 + 64'(cyc));
                driveFlit(1, 64'h200 + 64'(cyc));
            end
            step();
            if (bus.o_rdi_lp_valid === 1'b1) begin
                if (idx < 6) begin
                    expCh   = CH_W'(idx % 2);
                    expData = ((idx % 2) == 1 ? 64'h200 : 64'h100) + 64'(idx / 2);
                    nCompared++;
                    if (bus.o_rdi_lp_ch !== expCh || bus.o_rdi_lp_data !== expData) begin
                        nMismatched++;
                        $display("[TB] FAIL rr_order[%0d]: got ch=%0d data=%h expected ch=%0d data=%h",
                                 idx, bus.o_rdi_lp_ch, bus.o_rdi_lp_data, expCh, expData);
                    end
                end
                idx++;
            end
        end
        clearInputs();
        nCompared++;
        if (idx !== 6) begin
            nMismatched++;
            $display("[TB] FAIL rr_count: got %0d flits expected 6", idx);
        end
    endtask

    task automatic test_overflow();
        int idx;
        logic [DATA_W-1:0] expData;
        resetDut();
        goActive();
        bus.i_rdi_pl_trdy = 1'b0;
        driveFlit(0, 64'hC0);
        step();
        clearInputs();
        step();
        nCompared++;
        if (bus.o_rdi_lp_valid !== 1'b1 || bus.o_rdi_lp_data !== 64'hC0) begin
            nMismatched++;
            $display("[TB] FAIL ovf_hold: got v=%b data=%h expected 1/c0", bus.o_rdi_lp_valid, bus.o_rdi_lp_data);
        end
        for (int k = 0; k < 9; k++) begin
            nCompared++;
            if (bus.o_fdi_pl_trdy[1] !== (k < 8 ? 1'b1 : 1'b0)) begin
                nMismatched++;
                $display("[TB] FAIL ovf_trdy[%0d]: got %b expected %b", k, bus.o_fdi_pl_trdy[1], (k < 8 ? 1'b1 : 1'b0));
            end
            driveFlit(1, 64'h300 + 64'(k));
            step();
            clearInputs();
        end
        nCompared++;
        if (bus.o_tx_overf_err !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL ovf_flag: got %b expected 10", bus.o_tx_overf_err);
        end
        bus.i_rdi_pl_trdy = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (bus.o_rdi_lp_valid === 1'b1) begin
                expData = (idx == 0) ? 64'hC0 : 64'h300 + 64'(idx - 1);
                if (idx < 9) begin
                    nCompared++;
                    if (bus.o_rdi_lp_data !== expData) begin
                        nMismatched++;
                        $display("[TB] FAIL ovf_drain[%0d]: got %h expected %h", idx, bus.o_rdi_lp_data, expData);
                    end
                end
                idx++;
            end
            step();
        end
        nCompared++;
        if (idx !== 9) begin
            nMismatched++;
            $display("[TB] FAIL ovf_count: got %0d flits expected 9", idx);
        end
        bus.i_fdi_pl_state_sts = STS_RESET;
        step();
        step();
        nCompared++;
        if (bus.o_tx_overf_err !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL ovf_sticky: got %b expected 10", bus.o_tx_overf_err);
        end
        rst = 1'b1;
        step();
        nCompared++;
        if (bus.o_tx_overf_err !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL ovf_clear: got %b expected 00", bus.o_tx_overf_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_backpressure();
        resetDut();
        goActive();
        bus.i_rdi_pl_trdy = 1'b0;
        driveFlit(1, 64'hBEEF);
        step();
        clearInputs();
        step();
        for (int cyc = 0; cyc < 6; cyc++) begin
            nCompared++;
            if (bus.o_rdi_lp_valid !== 1'b1 || bus.o_rdi_lp_data !== 64'hBEEF || bus.o_rdi_lp_ch !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL bp_hold[%0d]: got v=%b data=%h ch=%0d expected 1/beef/1",
                         cyc, bus.o_rdi_lp_valid, bus.o_rdi_lp_data, bus.o_rdi_lp_ch);
            end
            if (cyc < 5) step();
        end
        bus.i_rdi_pl_trdy = 1'b1;
        step();
        nCompared++;
        if (bus.o_rdi_lp_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL bp_release: got valid=%b expected 0", bus.o_rdi_lp_valid);
        end
    endtask

    task automatic test_retrain_drain();
        int idx;
        logic [DATA_W-1:0] expD [4];
        logic [CH_W-1:0]   expC [4];
        expD = '{64'h400, 64'h500, 64'h401, 64'h501};
        expC = '{1'b0, 1'b1, 1'b0, 1'b1};
        resetDut();
        goActive();
        bus.i_rdi_pl_trdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            clearInputs();
            driveFlit(0, 64'h400 + 64'(k));
            driveFlit(1, 64'h500 + 64'(k));
            step();
        end
        clearInputs();
        bus.i_fdi_pl_state_sts = STS_RETRAIN;
        step();
        nCompared++;
        if (bus.o_fdi_pl_trdy !== 2'b00 || bus.o_tx_drained !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL drain_enter: got trdy=%b drained=%b expected 00/0", bus.o_fdi_pl_trdy, bus.o_tx_drained);
        end
        bus.i_rdi_pl_trdy = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (bus.o_rdi_lp_valid === 1'b1) begin
                if (idx < 4) begin
                    nCompared++;
                    if (bus.o_rdi_lp_data !== expD[idx] || bus.o_rdi_lp_ch !== expC[idx]) begin
                        nMismatched++;
                        $display("[TB] FAIL drain_flit[%0d]: got ch=%0d data=%h expected ch=%0d data=%h",
                                 idx, bus.o_rdi_lp_ch, bus.o_rdi_lp_data, expC[idx], expD[idx]);
                    end
                end
                idx++;
            end
            step();
        end
        nCompared++;
        if (idx !== 4 || bus.o_tx_drained !== 1'b1 || bus.o_fdi_pl_trdy !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL drain_done: got flits=%0d drained=%b trdy=%b expected 4/1/00",
                     idx, bus.o_tx_drained, bus.o_fdi_pl_trdy);
        end
        bus.i_fdi_pl_state_sts = STS_ACTIVE;
        step();
        nCompared++;
        if (bus.o_fdi_pl_trdy !== 2'b11 || bus.o_tx_drained !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL drain_resume: got trdy=%b drained=%b expected 11/0", bus.o_fdi_pl_trdy, bus.o_tx_drained);
        end
    endtask

    task automatic test_flush();
        logic staleSeen;
        resetDut();
        goActive();
        bus.i_rdi_pl_trdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            clearInputs();
            driveFlit(0, 64'h600 + 64'(k));
            driveFlit(1, 64'h700 + 64'(k));
            step();
        end
        clearInputs();
        bus.i_rdi_pl_trdy = 1'b1;
        step();
        nCompared++;
        if (bus.o_rdi_lp_valid !== 1'b1 || bus.o_rdi_lp_data !== 64'h700 || bus.o_rdi_lp_ch !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL flush_pre: got v=%b data=%h ch=%0d expected 1/700/1",
                     bus.o_rdi_lp_valid, bus.o_rdi_lp_data, bus.o_rdi_lp_ch);
        end
        bus.i_fdi_pl_state_sts = STS_RESET;
        step();
        nCompared++;
        if (bus.o_rdi_lp_valid !== 1'b0 || bus.o_fdi_pl_trdy !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL flush_kill: got valid=%b trdy=%b expected 0/00", bus.o_rdi_lp_valid, bus.o_fdi_pl_trdy);
        end
        bus.i_fdi_pl_state_sts = STS_ACTIVE;
        step();
        nCompared++;
        if (bus.o_fdi_pl_trdy !== 2'b11) begin
            nMismatched++;
            $display("[TB] FAIL flush_trdy: got %b expected 11", bus.o_fdi_pl_trdy);
        end
        staleSeen = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (bus.o_rdi_lp_valid !== 1'b0) staleSeen = 1'b1;
            step();
        end
        nCompared++;
        if (staleSeen !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL flush_stale: got stale flit=%b expected 0", staleSeen);
        end
    endtask

    initial begin
        $display("[TB] starting ucie_ctl_tx_mc directed tests");
        test_reset();
        test_single_flow();
        test_round_robin();
        test_overflow();
        test_backpressure();
        test_retrain_drain();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
